// File: rtl/serial_operand_feeder.sv
// Feeds a parallel operand pair LSB-first into a bit-serial adder: clear pulse, WIDTH bits, drain.
// Define SER_FEED_SKID_EN to add a one-entry holding register for back-to-back issue.
module serial_operand_feeder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DRAIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_cin,
  output logic                     adder_rst,
  output logic                     ser_a,
  output logic                     ser_b,
  output logic                     ser_cin,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     last_bit,
  output logic                     busy
);

  localparam int unsigned IW = $clog2(WIDTH);
  localparam int unsigned DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [IW-1:0] LastIdx   = IW'(WIDTH - 1);
  localparam logic [DW-1:0] LastDrain = DW'(DRAIN - 1);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDrain} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_a_q, sh_b_q;
  logic [DW-1:0]    drain_q;

  logic             hs, op_end, launch;
  logic [WIDTH-1:0] ld_a, ld_b;
  logic             ld_cin;

  assign hs = in_valid & in_ready;

  // Final cycle of the current operation; a new one may launch straight into CLEAR here.
  assign op_end = ((state_q == StShift) && (bit_idx == LastIdx) && (DRAIN == 0)) ||
                  ((state_q == StDrain) && (drain_q == LastDrain));

`ifdef SER_FEED_SKID_EN
  logic             hold_full_q;
  logic [WIDTH-1:0] hold_a_q, hold_b_q;
  logic             hold_cin_q;
  logic             hold_set, hold_clr;

  always_comb begin
    in_ready = !hold_full_q && !rst;
    launch   = 1'b0;
    hold_set = 1'b0;
    hold_clr = 1'b0;
    ld_a     = in_a;
    ld_b     = in_b;
    ld_cin   = in_cin;
    if (op_end && hold_full_q) begin
      launch   = 1'b1;
      hold_clr = 1'b1;
      ld_a     = hold_a_q;
      ld_b     = hold_b_q;
      ld_cin   = hold_cin_q;
    end else if (hs && (state_q == StIdle || op_end)) begin
      launch = 1'b1;
    end else if (hs) begin
      hold_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      hold_cin_q  <= 1'b0;
    end else if (hold_set) begin
      hold_full_q <= 1'b1;
      hold_a_q    <= in_a;
      hold_b_q    <= in_b;
      hold_cin_q  <= in_cin;
    end else if (hold_clr) begin
      hold_full_q <= 1'b0;
    end
  end
`else
  always_comb begin
    in_ready = (state_q == StIdle) && !rst;
    launch   = hs;
    ld_a     = in_a;
    ld_b     = in_b;
    ld_cin   = in_cin;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      drain_q   <= '0;
      adder_rst <= 1'b0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      ser_cin   <= 1'b0;
      bit_idx   <= '0;
      last_bit  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      adder_rst <= 1'b0;
      ser_a     <= 1'b0;
      ser_b     <= 1'b0;
      last_bit  <= 1'b0;
      if (launch) begin
        state_q   <= StClear;
        adder_rst <= 1'b1;
        sh_a_q    <= ld_a;
        sh_b_q    <= ld_b;
        ser_cin   <= ld_cin;
        bit_idx   <= '0;
        busy      <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;
          StClear: begin
            state_q <= StShift;
            ser_a   <= sh_a_q[0];
            ser_b   <= sh_b_q[0];
            sh_a_q  <= sh_a_q >> 1;
            sh_b_q  <= sh_b_q >> 1;
            bit_idx <= '0;
          end
          StShift: begin
            if (bit_idx == LastIdx) begin
              if (DRAIN == 0) begin
                state_q <= StIdle;
                busy    <= 1'b0;
              end else begin
                state_q <= StDrain;
                drain_q <= '0;
              end
            end else begin
              ser_a    <= sh_a_q[0];
              ser_b    <= sh_b_q[0];
              sh_a_q   <= sh_a_q >> 1;
              sh_b_q   <= sh_b_q >> 1;
              bit_idx  <= bit_idx + 1'b1;
              last_bit <= ((bit_idx + 1'b1) == LastIdx);
            end
          end
          StDrain: begin
            if (drain_q == LastDrain) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              drain_q <= drain_q + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: a DRAIN=2 and a DRAIN=0 instance share one stimulus stream,
// each checked every cycle against a timeline model of the operation.
module tb_serial_operand_feeder;

  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       in_cin = 1'b0;

  logic [1:0] rdy, ars, sa, sb, sc, lb, bz;
  logic [3:0] bi_all;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_operand_feeder #(.WIDTH(4), .DRAIN(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .adder_rst(ars[0]), .ser_a(sa[0]), .ser_b(sb[0]), .ser_cin(sc[0]),
    .bit_idx(bi_all[1:0]), .last_bit(lb[0]), .busy(bz[0])
  );

  serial_operand_feeder #(.WIDTH(4), .DRAIN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .adder_rst(ars[1]), .ser_a(sa[1]), .ser_b(sb[1]), .ser_cin(sc[1]),
    .bit_idx(bi_all[3:2]), .last_bit(lb[1]), .busy(bz[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Model: an op is a timeline of 1 + W + DRAIN cycles; pos 0 is the clear pulse.
  int         drn [2] = '{2, 0};
  logic       m_act [2] = '{1'b0, 1'b0};
  int         m_pos [2] = '{0, 0};
  logic [3:0] m_a [2], m_b [2];
  logic       m_cin [2];
  logic       m_hf [2] = '{1'b0, 1'b0};
  logic [3:0] m_ha [2], m_hb [2];
  logic       m_hc [2];

  function automatic logic exp_ready(input int i);
`ifdef SER_FEED_SKID_EN
    return !rst && !m_hf[i];
`else
    return !rst && !m_act[i];
`endif
  endfunction

  always @(posedge clk) begin : model
    logic hs, act, hf, c, hc, endop;
    int pos;
    logic [3:0] a, b, ha, hb;
    for (int i = 0; i < 2; i++) begin
      hs = in_valid && exp_ready(i);
      act = m_act[i]; pos = m_pos[i]; a = m_a[i]; b = m_b[i]; c = m_cin[i];
      hf = m_hf[i]; ha = m_ha[i]; hb = m_hb[i]; hc = m_hc[i];
      if (rst) begin
        act = 1'b0; hf = 1'b0;
      end else begin
        endop = act && (pos == W + drn[i]);
        if (act) pos++;
        if (endop) act = 1'b0;
`ifdef SER_FEED_SKID_EN
        if (endop && hf) begin
          act = 1'b1; pos = 0; a = ha; b = hb; c = hc; hf = 1'b0;
        end else if (hs && !act) begin
          act = 1'b1; pos = 0; a = in_a; b = in_b; c = in_cin;
        end else if (hs) begin
          hf = 1'b1; ha = in_a; hb = in_b; hc = in_cin;
        end
`else
        if (hs) begin
          act = 1'b1; pos = 0; a = in_a; b = in_b; c = in_cin;
        end
`endif
      end
      m_act[i] <= act; m_pos[i] <= pos; m_a[i] <= a; m_b[i] <= b; m_cin[i] <= c;
      m_hf[i] <= hf; m_ha[i] <= ha; m_hb[i] <= hb; m_hc[i] <= hc;
    end
  end

  always @(negedge clk) begin : compare
    logic ea, eb, ear, elb;
    int k;
    for (int i = 0; i < 2; i++) begin
      ea = 1'b0; eb = 1'b0; ear = 1'b0; elb = 1'b0; k = 0;
      if (m_act[i]) begin
        if (m_pos[i] == 0) ear = 1'b1;
        else if (m_pos[i] <= W) begin
          k = m_pos[i] - 1;
          ea = m_a[i][k]; eb = m_b[i][k]; elb = (k == W - 1);
        end
      end
      chk($sformatf("d%0d in_ready", i), 32'(rdy[i]), 32'(exp_ready(i)));
      chk($sformatf("d%0d adder_rst", i), 32'(ars[i]), 32'(ear));
      chk($sformatf("d%0d ser_a", i), 32'(sa[i]), 32'(ea));
      chk($sformatf("d%0d ser_b", i), 32'(sb[i]), 32'(eb));
      chk($sformatf("d%0d last_bit", i), 32'(lb[i]), 32'(elb));
      chk($sformatf("d%0d busy", i), 32'(bz[i]), 32'(m_act[i]));
      if (m_act[i]) chk($sformatf("d%0d ser_cin", i), 32'(sc[i]), 32'(m_cin[i]));
      if (m_act[i] && m_pos[i] >= 1 && m_pos[i] <= W)
        chk($sformatf("d%0d bit_idx", i), 32'(bi_all[2*i +: 2]), 32'(k));
    end
  end

  // Called at a negedge; leaves the bench on the negedge where adder_rst of dut is high.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (!ars[0] && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk({name, " clear timeout"}, 32'(ars[0]), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(rdy[0] && rdy[1]) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle timeout", 32'(rdy[0] && rdy[1]), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] ga, gb, gl;
    logic       r;
    int lows, clears, t;

    // Reset: everything low while rst is held
    repeat (3) @(negedge clk);
    chk("t1 outputs in rst", 32'({rdy[0], ars[0], sa[0], sb[0], sc[0], lb[0], bz[0]}), 32'd0);
    chk("t1 bit_idx in rst", 32'(bi_all), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t1 ready after rst", 32'(rdy[0]), 32'd1);

    // Single op, hand-computed bit stream
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 4'b1011; in_b = 4'b0110; in_cin = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    wait_clear("t2");
    chk("t2 cin at clear", 32'(sc[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ga[k] = sa[0]; gb[k] = sb[0]; gl[k] = lb[0];
      chk("t2 bit_idx", 32'(bi_all[1:0]), 32'(k));
    end
    chk("t2 ser_a stream", 32'(ga), 32'h0000000b);
    chk("t2 ser_b stream", 32'(gb), 32'h00000006);
    chk("t2 last_bit", 32'(gl), 32'h00000008);
    @(negedge clk);
    chk("t5 d0 ready after last bit", 32'(rdy[1]), 32'd1);
    chk("t5 d0 busy after last bit", 32'(bz[1]), 32'd0);
    chk("t2 drain1 ready", 32'(rdy[0]), 32'd0);
    chk("t2 drain1 cin", 32'(sc[0]), 32'd1);
    @(negedge clk);
    chk("t2 drain2 ready", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    chk("t2 ready after drain", 32'(rdy[0]), 32'd1);

    // Continuous valid, fresh pair each accept
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 4'h5; in_b = 4'h9; in_cin = 1'b0;
    @(negedge clk);
    wait_clear("t3");
    lows = 0; clears = 0;
    for (int c = 0; c < 24; c++) begin
      if (!rdy[0]) lows++;
      if (ars[0]) clears++;
      r = rdy[0];
      @(posedge clk); #1;
      if (r) begin
        in_a = 4'($urandom); in_b = 4'($urandom); in_cin = 1'($urandom);
      end
      @(negedge clk);
    end
    chk("t3 ready low cycles", 32'(lows), 32'd21);
    chk("t3 ops started", 32'(clears), 32'd3);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    wait_idle();

    // Reset mid-SHIFT at bit 2
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 4'hf; in_b = 4'hf; in_cin = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    wait_clear("t4");
    repeat (3) @(negedge clk);
    chk("t4 bit_idx before rst", 32'(bi_all[1:0]), 32'd2);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t4 after rst", 32'({bz[0], sa[0], sb[0], ars[0]}), 32'd0);
    lows = 0;
    repeat (6) begin
      @(negedge clk);
      if (sa[0] || sb[0] || ars[0]) lows++;
    end
    chk("t4 no bits after abort", 32'(lows), 32'd0);

`ifdef SER_FEED_SKID_EN
    // Skid: second pair taken during SHIFT, third stalls until the hold slot frees
    wait_idle();
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 4'h3; in_b = 4'hc; in_cin = 1'b0;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    wait_clear("t6");
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 4'ha; in_b = 4'h5; in_cin = 1'b1;
    @(negedge clk);
    chk("t6 ready with empty hold", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    in_a = 4'h7; in_b = 4'h1; in_cin = 1'b0;
    @(negedge clk);
    chk("t6 ready with full hold", 32'(rdy[0]), 32'd0);
    t = 2;
    do begin
      @(negedge clk);
      t++;
    end while (!ars[0] && t < 14);
    chk("t6 gapless clear", 32'(t), 32'd7);
    chk("t6 cin of second op", 32'(sc[0]), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
`endif

    @(negedge clk);
    wait_idle();
    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
